// File: rtl/fft_frame_loader.sv
// Serial-to-parallel frame loader for an 8-point FFT: collects eight complex
// samples, aligned on s_first, and presents them on x0..x7 with a one-cycle en strobe.
module fft_frame_loader #(
  parameter int DW = 24
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          s_valid,
  input  logic          s_first,
  input  logic [DW-1:0] s_real,
  input  logic [DW-1:0] s_imag,
  output logic          s_ready,
  output logic          en,
  output logic [DW-1:0] x0_real,
  output logic [DW-1:0] x0_imag,
  output logic [DW-1:0] x1_real,
  output logic [DW-1:0] x1_imag,
  output logic [DW-1:0] x2_real,
  output logic [DW-1:0] x2_imag,
  output logic [DW-1:0] x3_real,
  output logic [DW-1:0] x3_imag,
  output logic [DW-1:0] x4_real,
  output logic [DW-1:0] x4_imag,
  output logic [DW-1:0] x5_real,
  output logic [DW-1:0] x5_imag,
  output logic [DW-1:0] x6_real,
  output logic [DW-1:0] x6_imag,
  output logic [DW-1:0] x7_real,
  output logic [DW-1:0] x7_imag,
  output logic          frame_err,
  output logic [15:0]   drop_cnt,
  output logic [15:0]   frame_cnt
);

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic [2:0]    idx_q, idx_d;
  logic          s_ready_q, s_ready_d;
  logic          en_q, en_d;
  logic          frame_err_q, frame_err_d;
  logic [15:0]   drop_cnt_q, drop_cnt_d;
  logic [15:0]   frame_cnt_q, frame_cnt_d;
  logic [DW-1:0] x_re_q [8];
  logic [DW-1:0] x_re_d [8];
  logic [DW-1:0] x_im_q [8];
  logic [DW-1:0] x_im_d [8];
  logic [DW-1:0] stg_re_q [7];
  logic [DW-1:0] stg_re_d [7];
  logic [DW-1:0] stg_im_q [7];
  logic [DW-1:0] stg_im_d [7];
  logic          accept;

  assign accept = s_valid & s_ready_q;

  always_comb begin
    // NOTE: every output of this block gets a default first so no path infers a latch.
    state_d     = state_q;
    idx_d       = idx_q;
    s_ready_d   = 1'b1;
    en_d        = 1'b0;
    frame_err_d = 1'b0;
    drop_cnt_d  = drop_cnt_q;
    frame_cnt_d = frame_cnt_q;
    x_re_d      = x_re_q;
    x_im_d      = x_im_q;
    stg_re_d    = stg_re_q;
    stg_im_d    = stg_im_q;

    if (accept) begin
      unique case (state_q)
        IDLE: begin
          if (s_first) begin
            stg_re_d[0] = s_real;
            stg_im_d[0] = s_imag;
            idx_d       = 3'd1;
            state_d     = FILL;
          end else if (drop_cnt_q != 16'hFFFF) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
          end
        end
        FILL: begin
          if (s_first) begin
            // A new frame start while filling abandons the partial frame.
            frame_err_d = 1'b1;
            stg_re_d[0] = s_real;
            stg_im_d[0] = s_imag;
            idx_d       = 3'd1;
          end else if (idx_q == 3'd7) begin
            for (int i = 0; i < 7; i++) begin
              x_re_d[i] = stg_re_q[i];
              x_im_d[i] = stg_im_q[i];
            end
            x_re_d[7]   = s_real;
            x_im_d[7]   = s_imag;
            en_d        = 1'b1;
            frame_cnt_d = frame_cnt_q + 16'd1;
            idx_d       = 3'd0;
            state_d     = IDLE;
          end else begin
            stg_re_d[idx_q] = s_real;
            stg_im_d[idx_q] = s_imag;
            idx_d           = idx_q + 3'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignments so all flops update together.
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= 3'd0;
      s_ready_q   <= 1'b0;
      en_q        <= 1'b0;
      frame_err_q <= 1'b0;
      drop_cnt_q  <= 16'd0;
      frame_cnt_q <= 16'd0;
      for (int i = 0; i < 8; i++) begin
        x_re_q[i] <= '0;
        x_im_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      s_ready_q   <= s_ready_d;
      en_q        <= en_d;
      frame_err_q <= frame_err_d;
      drop_cnt_q  <= drop_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      x_re_q      <= x_re_d;
      x_im_q      <= x_im_d;
    end
  end

  // NOTE: staging storage is deliberately left unreset; it is always written before being read.
  always_ff @(posedge clk) begin
    stg_re_q <= stg_re_d;
    stg_im_q <= stg_im_d;
  end

  assign s_ready   = s_ready_q;
  assign en        = en_q;
  assign frame_err = frame_err_q;
  assign drop_cnt  = drop_cnt_q;
  assign frame_cnt = frame_cnt_q;

  assign x0_real = x_re_q[0];
  assign x0_imag = x_im_q[0];
  assign x1_real = x_re_q[1];
  assign x1_imag = x_im_q[1];
  assign x2_real = x_re_q[2];
  assign x2_imag = x_im_q[2];
  assign x3_real = x_re_q[3];
  assign x3_imag = x_im_q[3];
  assign x4_real = x_re_q[4];
  assign x4_imag = x_im_q[4];
  assign x5_real = x_re_q[5];
  assign x5_imag = x_im_q[5];
  assign x6_real = x_re_q[6];
  assign x6_imag = x_im_q[6];
  assign x7_real = x_re_q[7];
  assign x7_imag = x_im_q[7];

endmodule

// File: tb/tb_fft_frame_loader.sv
// Directed bench for fft_frame_loader: reset, framing, resync, gaps,
// back-to-back frames and mid-frame reset, each checked against hand-computed values.
module tb_fft_frame_loader;

  localparam int DW = 24;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          s_valid = 1'b0;
  logic          s_first = 1'b0;
  logic [DW-1:0] s_real = '0;
  logic [DW-1:0] s_imag = '0;
  logic          s_ready, en, frame_err;
  logic [15:0]   drop_cnt, frame_cnt;
  logic [DW-1:0] xr [8];
  logic [DW-1:0] xi [8];

  int checks = 0;
  int errors = 0;
  int en_cnt = 0;
  int ferr_cnt = 0;

  fft_frame_loader #(.DW(DW)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_first(s_first),
    .s_real(s_real), .s_imag(s_imag), .s_ready(s_ready), .en(en),
    .x0_real(xr[0]), .x0_imag(xi[0]), .x1_real(xr[1]), .x1_imag(xi[1]),
    .x2_real(xr[2]), .x2_imag(xi[2]), .x3_real(xr[3]), .x3_imag(xi[3]),
    .x4_real(xr[4]), .x4_imag(xi[4]), .x5_real(xr[5]), .x5_imag(xi[5]),
    .x6_real(xr[6]), .x6_imag(xi[6]), .x7_real(xr[7]), .x7_imag(xi[7]),
    .frame_err(frame_err), .drop_cnt(drop_cnt), .frame_cnt(frame_cnt)
  );

  initial forever #5 clk = ~clk;

  // Pulse counters; sampled at the rising edge, before the flops update.
  always @(posedge clk) begin
    if (en) en_cnt <= en_cnt + 1;
    if (frame_err) ferr_cnt <= ferr_cnt + 1;
  end

  task automatic push(input logic first, input logic [DW-1:0] re, input logic [DW-1:0] im);
    @(negedge clk);
    s_valid = 1'b1;
    s_first = first;
    s_real  = re;
    s_imag  = im;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      s_valid = 1'b0;
      s_first = 1'b0;
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    s_valid = 1'b0;
    rst_n   = 1'b0;
    @(negedge clk);
    rst_n   = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (s_ready !== 1'b0 || en !== 1'b0 || frame_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: s_ready=%b en=%b frame_err=%b, expected 0 0 0", s_ready, en, frame_err);
    end
    checks++;
    if (drop_cnt !== 16'd0 || frame_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_counts: drop_cnt=%0d frame_cnt=%0d, expected 0 0", drop_cnt, frame_cnt);
    end
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (xr[k] !== '0 || xi[k] !== '0) begin
        errors++;
        $display("FAIL reset_x%0d: got %h/%h, expected 0/0", k, xr[k], xi[k]);
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (s_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_reset: s_ready=%b, expected 1", s_ready);
    end
  endtask

  task automatic test_basic();
    logic [DW-1:0] er [8];
    int en_base;
    er = '{24'd10, 24'd20, 24'd30, 24'd40, 24'd10, 24'd20, 24'd30, 24'd40};
    en_base = en_cnt;
    idle(2);
    for (int k = 0; k < 8; k++) push(k == 0, er[k], '0);
    @(negedge clk);
    s_valid = 1'b0;
    checks++;
    if (en !== 1'b1 || frame_cnt !== 16'd1) begin
      errors++;
      $display("FAIL basic_en: en=%b frame_cnt=%0d, expected 1 1", en, frame_cnt);
    end
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (xr[k] !== er[k] || xi[k] !== '0) begin
        errors++;
        $display("FAIL basic_x%0d: got %h/%h, expected %h/0", k, xr[k], xi[k], er[k]);
      end
    end
    idle(2);
    checks++;
    if (en !== 1'b0 || xr[0] !== er[0] || xr[7] !== er[7] || en_cnt - en_base != 1) begin
      errors++;
      $display("FAIL basic_hold: en=%b x0=%h x7=%h pulses=%0d, expected 0 %h %h 1",
               en, xr[0], xr[7], en_cnt - en_base, er[0], er[7]);
    end
  endtask

  task automatic test_drop();
    logic [DW-1:0] er [8];
    logic [DW-1:0] ei [8];
    int en_base;
    for (int k = 0; k < 8; k++) begin
      er[k] = DW'(100 * k - 350);
      ei[k] = DW'(5 - 3 * k);
    end
    apply_reset();
    en_base = en_cnt;
    for (int k = 0; k < 3; k++) push(1'b0, DW'(7777 + k), DW'(k));
    for (int k = 0; k < 8; k++) push(k == 0, er[k], ei[k]);
    @(negedge clk);
    s_valid = 1'b0;
    checks++;
    if (en !== 1'b1 || drop_cnt !== 16'd3 || frame_cnt !== 16'd1) begin
      errors++;
      $display("FAIL drop_counts: en=%b drop_cnt=%0d frame_cnt=%0d, expected 1 3 1", en, drop_cnt, frame_cnt);
    end
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (xr[k] !== er[k] || xi[k] !== ei[k]) begin
        errors++;
        $display("FAIL drop_x%0d: got %h/%h, expected %h/%h", k, xr[k], xi[k], er[k], ei[k]);
      end
    end
    idle(2);
    checks++;
    if (en_cnt - en_base != 1) begin
      errors++;
      $display("FAIL drop_pulses: %0d en pulses, expected 1", en_cnt - en_base);
    end
  endtask

  task automatic test_resync();
    logic [DW-1:0] er [8];
    logic [DW-1:0] ei [8];
    int en_base, ferr_base;
    logic [15:0] fc;
    for (int k = 0; k < 8; k++) begin
      er[k] = DW'(500 + k);
      ei[k] = DW'(-k);
    end
    en_base = en_cnt;
    ferr_base = ferr_cnt;
    fc = frame_cnt;
    push(1'b1, 24'd1111, 24'd1);
    for (int k = 0; k < 3; k++) push(1'b0, DW'(2222 + k), 24'd2);
    for (int k = 0; k < 8; k++) begin
      push(k == 0, er[k], ei[k]);
      if (k == 1) begin
        checks++;
        if (frame_err !== 1'b1) begin
          errors++;
          $display("FAIL resync_err_pulse: frame_err=%b, expected 1", frame_err);
        end
      end
    end
    @(negedge clk);
    s_valid = 1'b0;
    checks++;
    if (en !== 1'b1 || frame_cnt !== fc + 16'd1) begin
      errors++;
      $display("FAIL resync_en: en=%b frame_cnt=%0d, expected 1 %0d", en, frame_cnt, fc + 16'd1);
    end
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (xr[k] !== er[k] || xi[k] !== ei[k]) begin
        errors++;
        $display("FAIL resync_x%0d: got %h/%h, expected %h/%h", k, xr[k], xi[k], er[k], ei[k]);
      end
    end
    idle(2);
    checks++;
    if (ferr_cnt - ferr_base != 1 || en_cnt - en_base != 1) begin
      errors++;
      $display("FAIL resync_pulses: frame_err=%0d en=%0d, expected 1 1", ferr_cnt - ferr_base, en_cnt - en_base);
    end
  endtask

  task automatic test_gaps();
    logic [DW-1:0] er [8];
    logic [DW-1:0] ei [8];
    int en_base;
    er = '{24'h000001, 24'h7FFFFF, 24'h800000, 24'hFFFFFF, 24'h123456, 24'hABCDEF, 24'h000000, 24'h555555};
    ei = '{24'h800000, 24'h7FFFFF, 24'h000002, 24'hFEDCBA, 24'h0F0F0F, 24'hF0F0F0, 24'hFFFFFE, 24'h2AAAAA};
    en_base = en_cnt;
    for (int k = 0; k < 8; k++) begin
      push(k == 0, er[k], ei[k]);
      if (k < 7) begin
        idle(k % 3 + 1);
        checks++;
        if (en !== 1'b0) begin
          errors++;
          $display("FAIL gaps_early_en: en=%b after sample %0d, expected 0", en, k);
        end
      end
    end
    @(negedge clk);
    s_valid = 1'b0;
    checks++;
    if (en !== 1'b1) begin
      errors++;
      $display("FAIL gaps_en: en=%b one cycle after sample 7, expected 1", en);
    end
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (xr[k] !== er[k] || xi[k] !== ei[k]) begin
        errors++;
        $display("FAIL gaps_x%0d: got %h/%h, expected %h/%h", k, xr[k], xi[k], er[k], ei[k]);
      end
    end
    idle(3);
    checks++;
    if (en_cnt - en_base != 1) begin
      errors++;
      $display("FAIL gaps_pulses: %0d en pulses, expected 1", en_cnt - en_base);
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] ar [8];
    logic [DW-1:0] ai [8];
    logic [DW-1:0] br [8];
    logic [DW-1:0] bi [8];
    for (int k = 0; k < 8; k++) begin
      ar[k] = DW'(3 * k + 1);
      ai[k] = DW'(k);
      br[k] = DW'(1000 - 7 * k);
      bi[k] = DW'(77 + k);
    end
    apply_reset();
    for (int i = 0; i <= 16; i++) begin
      @(negedge clk);
      checks++;
      if (en !== ((i == 8) || (i == 16))) begin
        errors++;
        $display("FAIL b2b_en_cycle%0d: en=%b, expected %b", i, en, (i == 8) || (i == 16));
      end
      if (i == 8) begin
        checks++;
        if (frame_cnt !== 16'd1) begin
          errors++;
          $display("FAIL b2b_cnt1: frame_cnt=%0d, expected 1", frame_cnt);
        end
        for (int k = 0; k < 8; k++) begin
          checks++;
          if (xr[k] !== ar[k] || xi[k] !== ai[k]) begin
            errors++;
            $display("FAIL b2b_a_x%0d: got %h/%h, expected %h/%h", k, xr[k], xi[k], ar[k], ai[k]);
          end
        end
      end
      if (i > 8 && i < 16) begin
        checks++;
        if (xr[0] !== ar[0] || xi[3] !== ai[3] || xr[7] !== ar[7]) begin
          errors++;
          $display("FAIL b2b_hold_cycle%0d: x0=%h x3i=%h x7=%h, expected %h %h %h",
                   i, xr[0], xi[3], xr[7], ar[0], ai[3], ar[7]);
        end
      end
      if (i == 16) begin
        checks++;
        if (frame_cnt !== 16'd2) begin
          errors++;
          $display("FAIL b2b_cnt2: frame_cnt=%0d, expected 2", frame_cnt);
        end
        for (int k = 0; k < 8; k++) begin
          checks++;
          if (xr[k] !== br[k] || xi[k] !== bi[k]) begin
            errors++;
            $display("FAIL b2b_b_x%0d: got %h/%h, expected %h/%h", k, xr[k], xi[k], br[k], bi[k]);
          end
        end
      end
      if (i < 16) begin
        s_valid = 1'b1;
        s_first = (i % 8) == 0;
        s_real  = (i < 8) ? ar[i % 8] : br[i % 8];
        s_imag  = (i < 8) ? ai[i % 8] : bi[i % 8];
      end else begin
        s_valid = 1'b0;
        s_first = 1'b0;
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] er [8];
    logic [DW-1:0] ei [8];
    int en_base, ferr_base;
    for (int k = 0; k < 8; k++) begin
      er[k] = DW'(40 * k + 9);
      ei[k] = DW'(-2 * k - 1);
    end
    for (int k = 0; k < 6; k++) push(k == 0, DW'(900 + k), DW'(k));
    @(negedge clk);
    s_valid = 1'b0;
    rst_n   = 1'b0;
    #1;
    checks++;
    if (s_ready !== 1'b0 || en !== 1'b0 || frame_err !== 1'b0 || frame_cnt !== 16'd0 || drop_cnt !== 16'd0) begin
      errors++;
      $display("FAIL midreset_flags: s_ready=%b en=%b frame_err=%b frame_cnt=%0d drop_cnt=%0d, expected all 0",
               s_ready, en, frame_err, frame_cnt, drop_cnt);
    end
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (xr[k] !== '0 || xi[k] !== '0) begin
        errors++;
        $display("FAIL midreset_x%0d: got %h/%h, expected 0/0", k, xr[k], xi[k]);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    en_base = en_cnt;
    ferr_base = ferr_cnt;
    for (int k = 0; k < 8; k++) push(k == 0, er[k], ei[k]);
    @(negedge clk);
    s_valid = 1'b0;
    checks++;
    if (en !== 1'b1 || frame_cnt !== 16'd1) begin
      errors++;
      $display("FAIL midreset_en: en=%b frame_cnt=%0d, expected 1 1", en, frame_cnt);
    end
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (xr[k] !== er[k] || xi[k] !== ei[k]) begin
        errors++;
        $display("FAIL midreset_x%0d_after: got %h/%h, expected %h/%h", k, xr[k], xi[k], er[k], ei[k]);
      end
    end
    idle(2);
    checks++;
    if (ferr_cnt - ferr_base != 0 || en_cnt - en_base != 1) begin
      errors++;
      $display("FAIL midreset_pulses: frame_err=%0d en=%0d, expected 0 1", ferr_cnt - ferr_base, en_cnt - en_base);
    end
  endtask

  initial begin
    #3;
    rst_n = 1'b0;
    test_reset();
    test_basic();
    test_drop();
    test_resync();
    test_gaps();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
